aes_round_sequencer: RTL and testbench

//  Top-level control FSM for the AES-128 encryption datapath. Sequences the per-round units
//  (SubBytes, ShiftRows, MixColumns, AddRoundKey) over NR rounds through their En_x/Ry_x handshake.

---
 rtl/aes_round_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Purpose:
//   Control FSM for an AES-128 encryption datapath. Holds the 128-bit AES
//   state register, broadcasts it to the SubBytes, ShiftRows, MixColumns and
//   AddRoundKey units on one shared bus (Dat_Unit), and steps those units
//   through NR rounds. Each unit's result is captured back into the state
//   register. The final round skips MixColumns.
//
// Ports:
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   Start, Plain_In     start request (sampled in IDLE only) and plaintext
//   Busy                high in every state except IDLE
//   Done                one-cycle pulse, Cipher_Out valid
//   Err                 one-cycle pulse, a unit failed to answer in time
//   Cipher_Out          ciphertext, updated only together with Done
//   Round               round index for the key schedule (0 = initial ARK)
//   Dat_Unit            state register, shared operand bus to all units
//   En_x / Ry_x / Out_x per-unit enable, ready and result (x = SB, SHR,
//                       MC, ARK)
//   State_Dbg           current FSM state encoding, for observation only
//
// Unit handshake:
//   On entry to a stage the sequencer raises En_x for exactly one cycle,
//   while Dat_Unit holds the operand. The unit answers by raising Ry_x with
//   Out_x valid in some later cycle; the first clock edge that sees Ry_x=1
//   after the En_x cycle captures Out_x and moves on. Ry_x in the En_x cycle
//   itself, and Ry from any unit other than the one being waited on, are
//   ignored. If no Ry_x arrives within TIMEOUT cycles (counting the En_x
//   cycle) Err pulses and the sequencer returns to IDLE.
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Start,
  input  logic [127:0] Plain_In,
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic [127:0] Cipher_Out,
  output logic [3:0]   Round,
  output logic [127:0] Dat_Unit,
  output logic         En_SB,
  input  logic         Ry_SB,
  input  logic [127:0] Out_SB,
  output logic         En_SHR,
  input  logic         Ry_SHR,
  input  logic [127:0] Out_SHR,
  output logic         En_MC,
  input  logic         Ry_MC,
  input  logic [127:0] Out_MC,
  output logic         En_ARK,
  input  logic         Ry_ARK,
  input  logic [127:0] Out_ARK,
  output logic [2:0]   State_Dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARK0 = 3'd1,
    S_SB   = 3'd2,
    S_SHR  = 3'd3,
    S_MC   = 3'd4,
    S_ARK  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [3:0] NR_L = 4'(NR);
  localparam logic [7:0] TO_L = 8'(TIMEOUT);

  state_e         state_q;
  logic [127:0]   data_q;
  logic [127:0]   cipher_q;
  logic [3:0]     round_q;
  logic [7:0]     timer_q;
  logic [7:0]     timer_d;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic           en_sb_q;
  logic           en_shr_q;
  logic           en_mc_q;
  logic           en_ark_q;

  logic           ry_sel;
  logic [127:0]   out_sel;
  logic           en_cycle;

  // Select the handshake of the unit owning the current stage; every other
  // unit's ready is simply not looked at.
  always_comb begin
    ry_sel  = 1'b0;
    out_sel = Out_ARK;
    case (state_q)
      S_ARK0, S_ARK: begin
        ry_sel  = Ry_ARK;
        out_sel = Out_ARK;
      end
      S_SB: begin
        ry_sel  = Ry_SB;
        out_sel = Out_SB;
      end
      S_SHR: begin
        ry_sel  = Ry_SHR;
        out_sel = Out_SHR;
      end
      S_MC: begin
        ry_sel  = Ry_MC;
        out_sel = Out_MC;
      end
      default: ;
    endcase
  end

  // The enable pulse marks the entry cycle of a stage; ready is not
  // accepted in that cycle.
  assign en_cycle = en_sb_q | en_shr_q | en_mc_q | en_ark_q;
  assign timer_d  = timer_q + 8'd1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      cipher_q <= '0;
      round_q  <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      en_sb_q  <= 1'b0;
      en_shr_q <= 1'b0;
      en_mc_q  <= 1'b0;
      en_ark_q <= 1'b0;
    end else begin
      // Pulses default low; a stage transition below re-raises one enable.
      en_sb_q  <= 1'b0;
      en_shr_q <= 1'b0;
      en_mc_q  <= 1'b0;
      en_ark_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (Start) begin
            data_q   <= Plain_In;
            round_q  <= '0;
            timer_q  <= '0;
            busy_q   <= 1'b1;
            en_ark_q <= 1'b1;
            state_q  <= S_ARK0;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          if (en_cycle) begin
            // The enable cycle already counts toward the timeout.
            timer_q <= timer_d;
          end else if (ry_sel) begin
            data_q  <= out_sel;
            timer_q <= '0;
            case (state_q)
              S_ARK0: begin
                round_q <= 4'd1;
                en_sb_q <= 1'b1;
                state_q <= S_SB;
              end
              S_SB: begin
                en_shr_q <= 1'b1;
                state_q  <= S_SHR;
              end
              S_SHR: begin
                // The last round has no MixColumns.
                if (round_q < NR_L) begin
                  en_mc_q <= 1'b1;
                  state_q <= S_MC;
                end else begin
                  en_ark_q <= 1'b1;
                  state_q  <= S_ARK;
                end
              end
              S_MC: begin
                en_ark_q <= 1'b1;
                state_q  <= S_ARK;
              end
              S_ARK: begin
                if (round_q < NR_L) begin
                  round_q <= round_q + 4'd1;
                  en_sb_q <= 1'b1;
                  state_q <= S_SB;
                end else begin
                  // Publish the ciphertext in the same cycle Done is high.
                  cipher_q <= out_sel;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end else if (timer_d >= TO_L) begin
            // Abort: state register keeps its partial contents, Cipher_Out
            // is left untouched.
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            round_q <= '0;
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
      endcase
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign Cipher_Out = cipher_q;
  assign Round      = round_q;
  assign Dat_Unit   = data_q;
  assign En_SB      = en_sb_q;
  assign En_SHR     = en_shr_q;
  assign En_MC      = en_mc_q;
  assign En_ARK     = en_ark_q;
  assign State_Dbg  = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Bench for aes_round_sequencer. Four behavioural AES units (SubBytes,
// ShiftRows, MixColumns, AddRoundKey with an internal FIPS-197 key schedule)
// answer the sequencer's enables after a fixed or random delay. Expected
// ciphertexts are queued when a run is started and compared when Done
// fires. Directed steps cover reset values, the FIPS-197 C.1 vector and its
// latency, stage ordering, handshake timeout, ignored Start/stray ready,
// mid-run reset, and random unit latency.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Start;
  logic [127:0] Plain_In;
  logic         Busy, Done, Err;
  logic [127:0] Cipher_Out, Dat_Unit;
  logic [3:0]   Round;
  logic         En_SB, En_SHR, En_MC, En_ARK;
  logic [2:0]   State_Dbg;

  logic [3:0]   ry_v = '0;
  logic [127:0] out_v [4] = '{default: '0};

  always #5 Clk = ~Clk;

  int ecnt = 0;
  always @(posedge Clk) ecnt++;

  aes_round_sequencer #(.NR(10), .TIMEOUT(255)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Plain_In(Plain_In),
    .Busy(Busy), .Done(Done), .Err(Err), .Cipher_Out(Cipher_Out),
    .Round(Round), .Dat_Unit(Dat_Unit),
    .En_SB(En_SB),   .Ry_SB(ry_v[0]),  .Out_SB(out_v[0]),
    .En_SHR(En_SHR), .Ry_SHR(ry_v[1]), .Out_SHR(out_v[1]),
    .En_MC(En_MC),   .Ry_MC(ry_v[2]),  .Out_MC(out_v[2]),
    .En_ARK(En_ARK), .Ry_ARK(ry_v[3]), .Out_ARK(out_v[3]),
    .State_Dbg(State_Dbg)
  );

  // ---------------- AES reference functions ----------------
  logic [127:0] rk [16];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0]  y, inv;
    logic [15:0] t;
    y = x; inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      y   = gmul(y, y);
      inv = gmul(inv, y);
    end
    t = {inv, inv};
    return inv ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
  endfunction

  function automatic logic [7:0] gbyte(logic [127:0] s, int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(gbyte(s, i));
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r[127-8*(rr+4*c) -: 8] = gbyte(s, rr + 4*((c+rr)%4));
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gbyte(s, 4*c); a1 = gbyte(s, 4*c+1);
      a2 = gbyte(s, 4*c+2); a3 = gbyte(s, 4*c+3);
      r[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] unit_fn(int u, logic [127:0] d, logic [3:0] r);
    case (u)
      0:       return sub_bytes(d);
      1:       return shift_rows(d);
      2:       return mix_columns(d);
      default: return d ^ rk[r];
    endcase
  endfunction

  // ---------------- unit models and event monitor ----------------
  bit   rand_mode = 1'b0;
  bit   withhold  = 1'b0;  // suppress Ry_SHR in round 3
  bit   spur_mc   = 1'b0;  // stray Ry_MC for one cycle
  int   cnt [4] = '{default: 0};
  logic [127:0] res [4];
  int   en_log [$];
  int   rnd_log [$];
  int   w_en_e = -1;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic [3:0] en_vec;
  assign en_vec = {En_ARK, En_MC, En_SHR, En_SB};

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (Err)  err_cnt++;
    for (int u = 0; u < 4; u++) begin
      ry_v[u] = 1'b0;
      if (en_vec[u]) begin
        en_log.push_back(u);
        rnd_log.push_back(int'(Round));
        if (u == 1 && Round == 4'd3) w_en_e = ecnt;
        cnt[u] = rand_mode ? int'($urandom_range(5, 1)) : 1;
        res[u] = unit_fn(u, Dat_Unit, Round);
      end else if (cnt[u] > 0) begin
        cnt[u]--;
        if (cnt[u] == 0 && !(withhold && u == 1 && Round == 4'd3)) begin
          ry_v[u]  = 1'b1;
          out_v[u] = res[u];
        end
      end
    end
    if (spur_mc) begin
      ry_v[2]  = 1'b1;
      out_v[2] = {4{32'hdeadbeef}};
    end
  end

  // ---------------- scoreboard / checking ----------------
  logic [127:0] exp_q [$];
  int exp_u [$];
  int exp_r [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [127:0] p, input bit push, output int s);
    Plain_In = p;
    Start    = 1'b1;
    if (push) exp_q.push_back(CIPHER);
    @(posedge Clk); #1;
    s     = ecnt;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int de);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge Clk); #1;
      if (Done) got = 1'b1;
    end
    de = ecnt;
    chk({tag, "_done_seen"}, got, 1'b1);
    if (got) begin
      chk({tag, "_sb_has_entry"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk({tag, "_cipher"}, Cipher_Out, exp_q.pop_front());
      chk({tag, "_busy_on_done"}, Busy, 1'b1);
      @(posedge Clk); #1;
      chk({tag, "_done_one_cycle"}, Done, 1'b0);
      chk({tag, "_busy_after"}, Busy, 1'b0);
    end
  endtask

  task automatic check_order(input string tag, input int base);
    int m;
    m = 0;
    if (en_log.size() - base != exp_u.size()) m = 1000 + en_log.size() - base;
    else
      for (int i = 0; i < exp_u.size(); i++)
        if (en_log[base+i] != exp_u[i] || rnd_log[base+i] != exp_r[i]) m++;
    chk({tag, "_stage_order"}, m, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t expected below 2000000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s, de, ee, base, d0, e0;
    bit got;

    Rst_n = 1'b0; Start = 1'b0; Plain_In = '0;
    key_expand(KEY);
    exp_u.push_back(3); exp_r.push_back(0);
    for (int r = 1; r <= 10; r++) begin
      exp_u.push_back(0); exp_r.push_back(r);
      exp_u.push_back(1); exp_r.push_back(r);
      if (r < 10) begin exp_u.push_back(2); exp_r.push_back(r); end
      exp_u.push_back(3); exp_r.push_back(r);
    end

    // Reset values
    repeat (3) @(posedge Clk); #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done_err", {Done, Err}, 2'b00);
    chk("rst_en", {En_SB, En_SHR, En_MC, En_ARK}, 4'b0);
    chk("rst_round", Round, 4'd0);
    chk("rst_dat", Dat_Unit, 128'h0);
    chk("rst_cipher", Cipher_Out, 128'h0);
    chk("rst_state", State_Dbg, 3'd0);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;

    // FIPS-197 C.1 with 1-cycle units, latency and stage ordering
    base = en_log.size(); d0 = done_cnt;
    start_run(PLAIN, 1'b1, s);
    chk("t1_busy_c1", Busy, 1'b1);
    chk("t1_en_ark_c1", En_ARK, 1'b1);
    chk("t1_round_c1", Round, 4'd0);
    chk("t1_dat_c1", Dat_Unit, PLAIN);
    wait_done("t1", 200, de);
    chk("t1_done_cycle", de - s + 1, 81);
    check_order("t1", base);
    chk("t1_done_count", done_cnt - d0, 1);

    // Ry_SHR withheld in round 3 -> timeout
    withhold = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    start_run(PLAIN, 1'b0, s);
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge Clk); #1;
      if (Err) got = 1'b1;
    end
    ee = ecnt;
    chk("t3_err_seen", got, 1'b1);
    chk("t3_err_delay", ee - w_en_e, 255);
    chk("t3_busy", Busy, 1'b0);
    chk("t3_round", Round, 4'd0);
    chk("t3_state_idle", State_Dbg, 3'd0);
    chk("t3_cipher_held", Cipher_Out, CIPHER);
    @(posedge Clk); #1;
    chk("t3_err_one_cycle", Err, 1'b0);
    chk("t3_err_count", err_cnt - e0, 1);
    chk("t3_no_done", done_cnt - d0, 0);
    withhold = 1'b0;
    repeat (3) @(posedge Clk); #1;

    // Start while busy and a stray Ry_MC during the SB wait are ignored
    base = en_log.size(); d0 = done_cnt;
    start_run(PLAIN, 1'b1, s);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("t4_en_sb_c3", En_SB, 1'b1);
    @(posedge Clk); #1;
    spur_mc = 1'b1;
    @(negedge Clk); #1;
    spur_mc = 1'b0;
    while (ecnt - s + 1 < 20) begin @(posedge Clk); #1; end
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done("t4", 200, de);
    chk("t4_done_cycle", de - s + 1, 81);
    check_order("t4", base);
    repeat (3) @(posedge Clk); #1;
    chk("t4_done_count", done_cnt - d0, 1);
    chk("t4_idle", Busy, 1'b0);

    // Reset in the middle of a run
    d0 = done_cnt; e0 = err_cnt;
    start_run(PLAIN, 1'b0, s);
    while (ecnt - s + 1 < 40) begin @(posedge Clk); #1; end
    #2 Rst_n = 1'b0;
    #1;
    chk("t5_busy", Busy, 1'b0);
    chk("t5_done_err", {Done, Err}, 2'b00);
    chk("t5_en", {En_SB, En_SHR, En_MC, En_ARK}, 4'b0);
    chk("t5_round", Round, 4'd0);
    chk("t5_dat", Dat_Unit, 128'h0);
    chk("t5_cipher", Cipher_Out, 128'h0);
    chk("t5_state", State_Dbg, 3'd0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (6) @(posedge Clk); #1;
    chk("t5_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    base = en_log.size(); d0 = done_cnt;
    start_run(PLAIN, 1'b1, s);
    wait_done("t5", 200, de);
    chk("t5_done_cycle", de - s + 1, 81);
    check_order("t5", base);

    // Random 1..5 cycle unit latency
    rand_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      repeat (2) @(posedge Clk); #1;
      base = en_log.size(); d0 = done_cnt;
      start_run(PLAIN, 1'b1, s);
      wait_done("t6", 600, de);
      check_order("t6", base);
      repeat (8) @(posedge Clk); #1;
      chk("t6_done_count", done_cnt - d0, 1);
    end
    rand_mode = 1'b0;

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
